psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter MAC_NUM, default 256: number of MAC lanes consumed; must be a multiple of OUT_LANES.
REQ-002 SHALL have parameter ACC_W, default 16: width of each signed lane accumulator.
REQ-003 SHALL have parameter OUT_LANES, default 2: accumulators packed per output beat.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port psum_in  input  6*MAC_NUM  per-lane signed 6-bit partial sums; lane i occupies bits [i*6+5 -: 6].
REQ-007 SHALL have port psum_valid  input  1  psum_in is valid this cycle.
REQ-008 SHALL have port psum_ready  output  1  block accepts psum_in this cycle.
REQ-009 SHALL have port psum_first  input  1  qualifies the accepted beat as the first pass: overwrite instead of add.
REQ-010 SHALL have port psum_last  input  1  qualifies the accepted beat as the final pass: start drain.
REQ-011 SHALL have port lane_enable  input  MAC_NUM  per-lane mask; a masked lane contributes zero.
REQ-012 SHALL have port m_axis_tdata  output  ACC_W*OUT_LANES  packed results; lowest lane in the LSBs.
REQ-013 SHALL have port m_axis_tvalid  output  1  output beat valid.
REQ-014 SHALL have port m_axis_tready  input  1  downstream accepts the beat.
REQ-015 SHALL have port m_axis_tlast  output  1  marks the final beat of a drain.
REQ-016 SHALL have port busy  output  1  high in ACCUM or DRAIN.

Function
REQ-017 SHALL implement an FSM with three states, IDLE, ACCUM and DRAIN, and SHALL drive psum_ready high in IDLE and ACCUM only.
REQ-018 SHALL define accept as psum_valid && psum_ready.
REQ-019 SHALL, on accept, update every lane on the next edge to (psum_first ? 0 : acc[i]) + sext(lane_enable[i] ? psum_in[i] : 0).
REQ-020 SHALL saturate each lane sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around.
REQ-021 SHALL transition IDLE->ACCUM on accept without psum_last, and IDLE/ACCUM->DRAIN on accept with psum_last; first and last together is a legal one-pass job.
REQ-022 SHALL treat accept in IDLE without psum_first as an add to the current accumulator contents.
REQ-023 SHALL, in DRAIN, present lanes [k*OUT_LANES +: OUT_LANES] on beat k, starting the cycle after the last accept (latency 1), for MAC_NUM/OUT_LANES beats.
REQ-024 SHALL hold tdata, tvalid and tlast stable while tvalid && !tready.
REQ-025 SHALL assert tlast only on beat MAC_NUM/OUT_LANES-1, and SHALL return to IDLE on its handshake, with tvalid low on the following cycle.
REQ-026 SHALL ignore psum_valid in DRAIN, because psum_ready is low there.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, all accumulators and the beat counter to 0, tvalid, tlast and busy to 0, and psum_ready to 1.
REQ-028 SHALL, on reset mid-ACCUM or mid-DRAIN, abandon the job and emit no further beats.

Configuration
REQ-029 SHALL, with ACC_RELU_EN defined, clamp each negative lane value to 0 on m_axis_tdata only, leaving stored accumulators unchanged.
REQ-030 SHALL, without ACC_RELU_EN, output signed accumulator values unmodified.

Structure
REQ-031 SHALL place the state encoding (IDLE/ACCUM/DRAIN) and the PSUM_W=6 constant in the shared package acc_pkg.
REQ-032 SHALL implement one lane as sub-module acc_lane (sign-extend, mask, add, saturate, register), instantiated MAC_NUM times in a generate loop.

Verification
REQ-033 SHALL cover: MAC_NUM=4, OUT_LANES=2, ACC_W=16, first+last beat with psums {1,-2,3,31} -> 2 beats {1,-2} then {3,31}, tlast on beat 2.
REQ-034 SHALL cover: three passes of +31 on all lanes (first, -, last) -> every lane reads 93.
REQ-035 SHALL cover: ACC_W=8, 10 passes of +31 -> lanes saturate at 127; 10 passes of -32 -> lanes saturate at -128.
REQ-036 SHALL cover: lane_enable=4'b0101 with psum 5 on all lanes -> lanes {5,0,5,0}.
REQ-037 SHALL cover: tready held low 3 cycles during beat 0 -> tdata stable, psum_ready=0, and psum_valid pulses ignored.
REQ-038 SHALL cover: rst_n pulsed low mid-DRAIN -> tvalid=0 immediately, next job starts from zeroed accumulators; with ACC_RELU_EN, psum -7 -> output 0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the partial-sum accumulator: controller states and partial-sum width.
package acc_pkg;

  localparam int unsigned PSUM_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  // Counter width that stays at least one bit wide for single-beat drains.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: sign-extend and mask the partial sum, add or overwrite,
// saturate to the signed accumulator range and register.
module acc_lane
  import acc_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              first_i,
  input  logic              en_i,
  input  logic [PSUM_W-1:0] psum_i,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [SUM_W-1:0] addend;
  logic signed [SUM_W-1:0] base;
  logic signed [SUM_W-1:0] sum;
  logic        [ACC_W-1:0] acc_q;
  logic        [ACC_W-1:0] acc_d;

  // One guard bit is enough: the sum of an ACC_W value and a 6-bit value cannot overflow ACC_W+1 bits.
  always_comb begin
    addend = en_i ? SUM_W'($signed(psum_i)) : '0;
    base   = first_i ? '0 : SUM_W'($signed(acc_q));
    sum    = base + addend;
    acc_d  = acc_q;
    if (load_i) begin
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
        acc_d = sum[SUM_W-1] ? MIN_V : MAX_V;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator with a streaming drain of OUT_LANES lanes per beat.
// Optional ACC_RELU_EN clamps negative lanes to zero on the output stream only.
module psum_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned MAC_NUM   = 256,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned OUT_LANES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PSUM_W*MAC_NUM-1:0]    psum_in,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  input  logic                         psum_first,
  input  logic                         psum_last,
  input  logic [MAC_NUM-1:0]           lane_enable,
  output logic [ACC_W*OUT_LANES-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy
);

  localparam int unsigned BEATS  = MAC_NUM / OUT_LANES;
  localparam int unsigned CNT_W  = cnt_w(BEATS);
  localparam int unsigned BEAT_W = ACC_W * OUT_LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  acc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               accept;
  logic [ACC_W*MAC_NUM-1:0] acc_flat;
  logic [BEAT_W-1:0]  beat_bus [BEATS];
  logic [BEAT_W-1:0]  beat_data;

  assign psum_ready = (state_q != DRAIN);
  assign busy       = (state_q != IDLE);
  assign accept     = psum_valid && psum_ready;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (accept),
      .first_i (psum_first),
      .en_i    (lane_enable[i]),
      .psum_i  (psum_in[i*PSUM_W +: PSUM_W]),
      .acc_o   (acc_flat[i*ACC_W +: ACC_W])
    );
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign beat_bus[b] = acc_flat[b*BEAT_W +: BEAT_W];
  end

  // Accumulators are frozen during DRAIN, so selecting by the beat register yields stable data.
  assign beat_data = beat_bus[beat_q];

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_out
    logic [ACC_W-1:0] lane_v;
    assign lane_v = beat_data[j*ACC_W +: ACC_W];
`ifdef ACC_RELU_EN
    assign m_axis_tdata[j*ACC_W +: ACC_W] = lane_v[ACC_W-1] ? '0 : lane_v;
`else
    assign m_axis_tdata[j*ACC_W +: ACC_W] = lane_v;
`endif
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (psum_last) begin
            state_d  = DRAIN;
            beat_d   = '0;
            tvalid_d = 1'b1;
            tlast_d  = (BEATS == 1);
          end else begin
            state_d  = ACCUM;
          end
        end
      end
      DRAIN: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d  = IDLE;
            beat_d   = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            beat_d   = CNT_W'(beat_q + 1'b1);
            tlast_d  = (beat_d == LAST_BEAT);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 16-bit and an 8-bit instance share stimulus
// (MAC_NUM=4, OUT_LANES=2); expectations honour ACC_RELU_EN when defined.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] psum_in;
  logic        psum_valid, psum_first, psum_last;
  logic [3:0]  lane_enable;
  logic        tready;

  logic        rdy_a, tvalid_a, tlast_a, busy_a;
  logic [31:0] tdata_a;
  logic        rdy_b, tvalid_b, tlast_b, busy_b;
  logic [15:0] tdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.MAC_NUM(4), .ACC_W(16), .OUT_LANES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(rdy_a), .psum_first(psum_first), .psum_last(psum_last),
    .lane_enable(lane_enable), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready), .m_axis_tlast(tlast_a), .busy(busy_a)
  );

  psum_accumulator #(.MAC_NUM(4), .ACC_W(8), .OUT_LANES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(rdy_b), .psum_first(psum_first), .psum_last(psum_last),
    .lane_enable(lane_enable), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready), .m_axis_tlast(tlast_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef ACC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic send(input int p0, input int p1, input int p2, input int p3,
                      input logic first, input logic last, input logic [3:0] en);
    @(negedge clk);
    psum_in     = {6'(p3), 6'(p2), 6'(p1), 6'(p0)};
    psum_valid  = 1'b1;
    psum_first  = first;
    psum_last   = last;
    lane_enable = en;
    @(posedge clk);
    #1;
    psum_valid  = 1'b0;
    psum_first  = 1'b0;
    psum_last   = 1'b0;
  endtask

  // Collect both beats of a drain and compare against per-instance lane expectations.
  task automatic drain(input string tag, input int ea [4], input int eb [4]);
    tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      while (!tvalid_a && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("%s_tvalid_b%0d", tag, k), int'(tvalid_a), 1);
      chk($sformatf("%s_tvalid8_b%0d", tag, k), int'(tvalid_b), 1);
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("%s_a_b%0d_l%0d", tag, k, j),
            int'($signed(tdata_a[j*16 +: 16])), relu(ea[k*2+j]));
        chk($sformatf("%s_b_b%0d_l%0d", tag, k, j),
            int'($signed(tdata_b[j*8 +: 8])), relu(eb[k*2+j]));
      end
      chk($sformatf("%s_tlast_b%0d", tag, k), int'(tlast_a), (k == 1) ? 1 : 0);
      chk($sformatf("%s_tlast8_b%0d", tag, k), int'(tlast_b), (k == 1) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    chk({tag, "_tvalid_after"}, int'(tvalid_a), 0);
    chk({tag, "_tvalid8_after"}, int'(tvalid_b), 0);
    chk({tag, "_ready_after"}, int'(rdy_a), 1);
    chk({tag, "_busy_after"}, int'(busy_a), 0);
  endtask

  initial begin
    logic [31:0] snap;
    rst_n       = 1'b0;
    psum_in     = '0;
    psum_valid  = 1'b0;
    psum_first  = 1'b0;
    psum_last   = 1'b0;
    lane_enable = 4'hF;
    tready      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", int'(tvalid_a), 0);
    chk("rst_tlast", int'(tlast_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_ready", int'(rdy_a), 1);
    chk("rst_tdata", int'(tdata_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-pass job.
    send(1, -2, 3, 31, 1'b1, 1'b1, 4'hF);
    chk("onepass_busy", int'(busy_a), 1);
    chk("onepass_ready", int'(rdy_a), 0);
    drain("onepass", '{1, -2, 3, 31}, '{1, -2, 3, 31});

    // Three passes of +31.
    send(31, 31, 31, 31, 1'b1, 1'b0, 4'hF);
    chk("three_busy_accum", int'(busy_a), 1);
    chk("three_ready_accum", int'(rdy_a), 1);
    send(31, 31, 31, 31, 1'b0, 1'b0, 4'hF);
    send(31, 31, 31, 31, 1'b0, 1'b1, 4'hF);
    drain("three", '{93, 93, 93, 93}, '{93, 93, 93, 93});

    // Positive and negative saturation.
    for (int p = 0; p < 10; p++) send(31, 31, 31, 31, p == 0, p == 9, 4'hF);
    drain("satpos", '{310, 310, 310, 310}, '{127, 127, 127, 127});
    for (int p = 0; p < 10; p++) send(-32, -32, -32, -32, p == 0, p == 9, 4'hF);
    drain("satneg", '{-320, -320, -320, -320}, '{-128, -128, -128, -128});

    // Lane mask, then an IDLE accept without first that adds on top.
    send(5, 5, 5, 5, 1'b1, 1'b1, 4'b0101);
    drain("mask", '{5, 0, 5, 0}, '{5, 0, 5, 0});
    send(1, 1, 1, 1, 1'b0, 1'b1, 4'hF);
    drain("addidle", '{6, 1, 6, 1}, '{6, 1, 6, 1});

    // Backpressure on beat 0 with psum_valid pulses that must be ignored.
    tready = 1'b0;
    send(10, -20, 30, -31, 1'b1, 1'b1, 4'hF);
    snap = tdata_a;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      psum_in    = {4{6'd31}};
      psum_valid = 1'b1;
      psum_first = 1'b1;
      psum_last  = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("stall_tdata_c%0d", c), int'(tdata_a == snap), 1);
      chk($sformatf("stall_ready_c%0d", c), int'(rdy_a), 0);
      chk($sformatf("stall_tvalid_c%0d", c), int'(tvalid_a), 1);
    end
    psum_valid = 1'b0;
    psum_first = 1'b0;
    psum_last  = 1'b0;
    drain("stall", '{10, -20, 30, -31}, '{10, -20, 30, -31});

    // Reset mid-drain abandons the job and clears the accumulators.
    tready = 1'b0;
    send(2, 2, 2, 2, 1'b1, 1'b1, 4'hF);
    chk("rstmid_tvalid_pre", int'(tvalid_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", int'(tvalid_a), 0);
    chk("rstmid_busy", int'(busy_a), 0);
    chk("rstmid_ready", int'(rdy_a), 1);
    @(negedge clk);
    rst_n  = 1'b1;
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_no_beats", int'(tvalid_a), 0);
    send(-7, 1, 2, 3, 1'b0, 1'b1, 4'hF);
    drain("postrst", '{-7, 1, 2, 3}, '{-7, 1, 2, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
